// File: rtl/neuron_lanes.sv
// neuron_lanes: LANES-wide fixed-point neuron with weight memory, saturating MAC, bias and activation.
// Define NEURON_OVF_EN to build the sticky saturation flag on ovf; without it ovf is tied low.
module neuron_lanes #(
    parameter int LAYER_NO   = 0,
    parameter int NEURON_NO  = 0,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int LANES      = 4,
    parameter int NUM_WEIGHT = 784,
    localparam int ADDR_W    = $clog2(NUM_WEIGHT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    input  logic                        cfg_is_bias,
    input  logic [31:0]                 cfg_layer,
    input  logic [31:0]                 cfg_neuron,
    input  logic [ADDR_W-1:0]           cfg_addr,
    input  logic [DATA_WIDTH-1:0]       cfg_data,
    input  logic [1:0]                  act_mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        ovf
);
    localparam int BEATS  = NUM_WEIGHT / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int ACC_W  = 2 * DATA_WIDTH;
    localparam int SUM_W  = ACC_W + $clog2(LANES);
    localparam int EXT_W  = SUM_W + 1;
    localparam int B_W    = ACC_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_BIAS, S_OUT} state_t;

    state_t                       state, next_state;
    logic                         in_ready_d;
    logic                         in_hs, last_beat;
    logic                         cfg_ok, weight_we, bias_we;
    logic [BEAT_W-1:0]            cfg_row, beat_cnt;
    logic [LANE_W-1:0]            cfg_lane;
    logic [1:0]                   act_q;
    logic                         s1_valid, s2_valid;
    logic signed [DATA_WIDTH-1:0] wmem [BEATS][LANES];
    logic signed [DATA_WIDTH-1:0] rd_w [LANES];
    logic signed [DATA_WIDTH-1:0] s1_x [LANES];
    logic signed [ACC_W-1:0]      prod [LANES];
    logic signed [SUM_W-1:0]      psum;
    logic signed [EXT_W-1:0]      acc_ext;
    logic signed [B_W-1:0]        b_ext;
    logic signed [ACC_W-1:0]      acc, acc_next, bias_sh, biased, shifted;
    logic signed [DATA_WIDTH-1:0] bias, narrow, act_out;
    logic                         acc_sat, b_sat, n_sat;

    assign in_hs     = in_valid && in_ready;
    assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
    assign out_valid = (state == S_OUT);

    assign cfg_ok    = cfg_valid && (state == S_IDLE) &&
                       (cfg_layer == 32'(LAYER_NO)) && (cfg_neuron == 32'(NEURON_NO));
    assign bias_we   = cfg_ok && cfg_is_bias;
    assign weight_we = cfg_ok && !cfg_is_bias && (32'(cfg_addr) < NUM_WEIGHT);
    assign cfg_row   = BEAT_W'(32'(cfg_addr) / LANES);
    assign cfg_lane  = LANE_W'(32'(cfg_addr) % LANES);

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE, S_ACCUM: if (in_hs) next_state = last_beat ? S_DRAIN : S_ACCUM;
            S_DRAIN:         if (!s1_valid && !s2_valid) next_state = S_BIAS;
            S_BIAS:          next_state = S_OUT;
            S_OUT:           if (out_ready) next_state = S_IDLE;
            default:         next_state = S_IDLE;
        endcase
        in_ready_d = (next_state == S_IDLE) || (next_state == S_ACCUM);
    end

    // Wide MAC path: lanes summed exactly, then clamped into the accumulator range.
    always_comb begin
        psum = '0;
        for (int k = 0; k < LANES; k++) psum = psum + SUM_W'(prod[k]);
        acc_ext  = EXT_W'(acc) + EXT_W'(psum);
        acc_sat  = !(&acc_ext[EXT_W-1:ACC_W-1]) && (|acc_ext[EXT_W-1:ACC_W-1]);
        acc_next = acc_sat ? {acc_ext[EXT_W-1], {(ACC_W-1){~acc_ext[EXT_W-1]}}}
                           : acc_ext[ACC_W-1:0];

        bias_sh = ACC_W'(bias) <<< FRAC_BITS;
        b_ext   = B_W'(acc) + B_W'(bias_sh);
        b_sat   = b_ext[B_W-1] ^ b_ext[ACC_W-1];
        biased  = b_sat ? {b_ext[B_W-1], {(ACC_W-1){~b_ext[B_W-1]}}} : b_ext[ACC_W-1:0];

        shifted = biased >>> FRAC_BITS;
        n_sat   = !(&shifted[ACC_W-1:DATA_WIDTH-1]) && (|shifted[ACC_W-1:DATA_WIDTH-1]);
        narrow  = n_sat ? {shifted[ACC_W-1], {(DATA_WIDTH-1){~shifted[ACC_W-1]}}}
                        : shifted[DATA_WIDTH-1:0];

        unique case (act_q)
            2'd1:    act_out = narrow[DATA_WIDTH-1] ? '0 : narrow;
            2'd2:    act_out = narrow[DATA_WIDTH-1] ? (narrow >>> 3) : narrow;
            default: act_out = narrow;
        endcase
    end

    // NOTE: weights and the data pipeline carry no reset, so a reset never wipes loaded weights.
    always_ff @(posedge clk) begin
        if (weight_we) wmem[cfg_row][cfg_lane] <= cfg_data;
        if (in_hs) begin
            for (int k = 0; k < LANES; k++) begin
                rd_w[k] <= wmem[beat_cnt][k];
                s1_x[k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (s1_valid) begin
            for (int k = 0; k < LANES; k++) prod[k] <= s1_x[k] * rd_w[k];
        end
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            beat_cnt <= '0;
            act_q    <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            acc      <= '0;
            bias     <= '0;
            out_data <= '0;
        end else begin
            state    <= next_state;
            in_ready <= in_ready_d;
            s1_valid <= in_hs;
            s2_valid <= s1_valid;
            if (in_hs) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            if (in_hs && state == S_IDLE) act_q <= act_mode;
            if (bias_we) bias <= cfg_data;
            if (state == S_IDLE) begin
                acc <= '0;
            end else if (s2_valid) begin
                acc <= acc_next;
            end else if (state == S_BIAS) begin
                acc      <= biased;
                out_data <= act_out;
            end
        end
    end

`ifdef NEURON_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (out_valid && out_ready) begin
            ovf_q <= 1'b0;
        end else if ((s2_valid && acc_sat) || (state == S_BIAS && (b_sat || n_sat))) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_lanes.sv
// tb_neuron_lanes: directed self-checking bench for neuron_lanes (LANES=4, NUM_WEIGHT=8, Q8.8).
module tb_neuron_lanes;
    localparam int DW    = 16;
    localparam int LANES = 4;
    localparam int NW    = 8;
    localparam int AW    = 3;
`ifdef NEURON_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                cfg_valid = 1'b0, cfg_is_bias = 1'b0;
    logic [31:0]         cfg_layer = '0, cfg_neuron = '0;
    logic [AW-1:0]       cfg_addr = '0;
    logic [DW-1:0]       cfg_data = '0;
    logic [1:0]          act_mode = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [LANES*DW-1:0] in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [DW-1:0]       out_data;
    logic                ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    neuron_lanes #(
        .LAYER_NO(0), .NEURON_NO(0), .DATA_WIDTH(DW), .FRAC_BITS(8),
        .LANES(LANES), .NUM_WEIGHT(NW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_is_bias(cfg_is_bias), .cfg_layer(cfg_layer),
        .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .act_mode(act_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .ovf(ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic is_bias, input int layer, input int neuron,
                             input int addr, input logic [DW-1:0] data);
        cfg_valid   = 1'b1;
        cfg_is_bias = is_bias;
        cfg_layer   = 32'(layer);
        cfg_neuron  = 32'(neuron);
        cfg_addr    = AW'(addr);
        cfg_data    = data;
        tick();
        cfg_valid   = 1'b0;
    endtask

    task automatic load_weights(input logic [DW-1:0] w, input logic [DW-1:0] b);
        for (int a = 0; a < NW; a++) cfg_write(1'b0, 0, 0, a, w);
        cfg_write(1'b1, 0, 0, 0, b);
    endtask

    // Returns just after the edge on which the beat was accepted.
    task automatic send_beat(input logic [DW-1:0] x);
        int n;
        in_data  = {LANES{x}};
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL in_ready_timeout: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_vector(input logic [DW-1:0] x, input logic [1:0] mode, input int gap);
        act_mode = mode;
        send_beat(x);
        for (int g = 0; g < gap; g++) tick();
        send_beat(x);
    endtask

    // lat counts edges after the last handshake edge until out_valid is seen.
    task automatic get_result(output logic [DW-1:0] data, output logic o, output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        if (out_valid !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL out_valid_timeout: got %b expected 1", out_valid);
        end
        data = out_data;
        o    = ovf;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_vec++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (out_data !== '0)    begin n_err++; $display("FAIL rst_out_data: got %h expected 0000", out_data); end
        n_vec++; if (ovf !== 1'b0)       begin n_err++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
        rst = 1'b1;
        tick();
        n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic_mac();
        logic [DW-1:0] d;
        logic          o;
        int            lat;
        load_weights(16'h0100, 16'h0080);
        send_vector(16'h0100, 2'd0, 0);
        get_result(d, o, lat);
        // Handshake in cycle T, out_valid in T+5: four edges after the handshake edge.
        n_vec++; if (d !== 16'h0880) begin n_err++; $display("FAIL basic_data: got %h expected 0880", d); end
        n_vec++; if (lat != 4)       begin n_err++; $display("FAIL basic_latency: got %0d expected 4", lat); end
        n_vec++; if (o !== 1'b0)     begin n_err++; $display("FAIL basic_ovf: got %b expected 0", o); end
    endtask

    task automatic test_act_modes();
        logic [DW-1:0] exp_d [4] = '{16'hF800, 16'h0000, 16'hFF00, 16'hF800};
        logic [DW-1:0] d;
        logic          o;
        int            lat;
        cfg_write(1'b1, 0, 0, 0, 16'h0000);
        for (int m = 0; m < 4; m++) begin
            send_vector(16'hFF00, 2'(m), 0);
            get_result(d, o, lat);
            n_vec++;
            if (d !== exp_d[m]) begin
                n_err++;
                $display("FAIL act_mode%0d: got %h expected %h", m, d, exp_d[m]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [DW-1:0] d;
        logic          o;
        int            lat;
        load_weights(16'h7FFF, 16'h0000);
        send_vector(16'h7FFF, 2'd0, 0);
        get_result(d, o, lat);
        n_vec++; if (d !== 16'h7FFF) begin n_err++; $display("FAIL sat_pos_data: got %h expected 7fff", d); end
        n_vec++; if (o !== OVF_EXP)  begin n_err++; $display("FAIL sat_pos_ovf: got %b expected %b", o, OVF_EXP); end
        n_vec++; if (ovf !== 1'b0)   begin n_err++; $display("FAIL sat_ovf_clear: got %b expected 0", ovf); end
        send_vector(16'h8000, 2'd0, 0);
        get_result(d, o, lat);
        n_vec++; if (d !== 16'h8000) begin n_err++; $display("FAIL sat_neg_data: got %h expected 8000", d); end
        n_vec++; if (o !== OVF_EXP)  begin n_err++; $display("FAIL sat_neg_ovf: got %b expected %b", o, OVF_EXP); end
    endtask

    task automatic test_gaps();
        logic [DW-1:0] d;
        logic          o;
        int            lat;
        load_weights(16'h0100, 16'h0080);
        send_vector(16'h0100, 2'd0, 3);
        get_result(d, o, lat);
        n_vec++; if (d !== 16'h0880) begin n_err++; $display("FAIL gap_data: got %h expected 0880", d); end
    endtask

    task automatic test_backpressure();
        int n;
        send_vector(16'h0100, 2'd0, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_vec++; if (out_data !== 16'h0880) begin n_err++; $display("FAIL bp_hold_data c%0d: got %h expected 0880", c, out_data); end
            n_vec++; if (in_ready !== 1'b0)     begin n_err++; $display("FAIL bp_in_ready c%0d: got %b expected 0", c, in_ready); end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_cfg_robust();
        logic [DW-1:0] d;
        logic          o;
        int            lat;
        for (int a = 0; a < NW; a++) cfg_write(1'b0, 0, 1, a, 16'h0200);
        for (int a = 0; a < NW; a++) cfg_write(1'b0, 1, 0, a, 16'h0200);
        cfg_write(1'b1, 0, 1, 0, 16'h0300);
        send_vector(16'h0100, 2'd0, 0);
        get_result(d, o, lat);
        n_vec++; if (d !== 16'h0880) begin n_err++; $display("FAIL cfg_mismatch: got %h expected 0880", d); end

        act_mode = 2'd0;
        send_beat(16'h0100);
        for (int a = 4; a < NW; a++) cfg_write(1'b0, 0, 0, a, 16'h0300);
        cfg_write(1'b1, 0, 0, 0, 16'h0000);
        send_beat(16'h0100);
        get_result(d, o, lat);
        n_vec++; if (d !== 16'h0880) begin n_err++; $display("FAIL cfg_in_accum: got %h expected 0880", d); end
        send_vector(16'h0100, 2'd0, 0);
        get_result(d, o, lat);
        n_vec++; if (d !== 16'h0880) begin n_err++; $display("FAIL cfg_after_accum: got %h expected 0880", d); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        logic          o;
        int            lat;
        act_mode = 2'd0;
        send_beat(16'h0100);
        tick();
        rst = 1'b0;
        #1;
        n_vec++; if (out_data !== '0)    begin n_err++; $display("FAIL mid_rst_data: got %h expected 0000", out_data); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
        n_vec++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL mid_rst_ready: got %b expected 0", in_ready); end
        tick();
        rst = 1'b1;
        tick();
        n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL mid_idle_ready: got %b expected 1", in_ready); end
        // Bias cleared by reset, weights kept.
        send_vector(16'h0100, 2'd0, 0);
        get_result(d, o, lat);
        n_vec++; if (d !== 16'h0800) begin n_err++; $display("FAIL mid_no_bias: got %h expected 0800", d); end
        cfg_write(1'b1, 0, 0, 0, 16'h0080);
        send_vector(16'h0100, 2'd0, 0);
        get_result(d, o, lat);
        n_vec++; if (d !== 16'h0880) begin n_err++; $display("FAIL mid_reload_bias: got %h expected 0880", d); end
    endtask

    initial begin
        test_reset();
        test_basic_mac();
        test_act_modes();
        test_saturation();
        test_gaps();
        test_backpressure();
        test_cfg_robust();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
